// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH register file: one synchronous write port, two registered read
// ports with same-cycle write forwarding, optional hard-wired zero word.
module regfile_2r1w #(
    parameter int WIDTH    = 17,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re1,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    output logic             rvalid1,
    input  logic             re2,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata2,
    output logic             rvalid2,
    output logic             err
);

    // One extra bit so DEPTH == 2**AW is still representable.
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam bit          ZR      = (ZERO_REG != 0);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata1, r_rdata2;
    logic             r_rvalid1, r_rvalid2, r_err;

    logic             w_wr_en;
    logic             w_err;
    logic [WIDTH-1:0] w_mem_rd1, w_mem_rd2;
    logic [WIDTH-1:0] w_rd1, w_rd2;

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    function automatic logic [WIDTH-1:0] port_value(
        input logic [AW-1:0]    a,
        input logic [WIDTH-1:0] memv,
        input logic             wr_en,
        input logic [AW-1:0]    wa,
        input logic [WIDTH-1:0] wd
    );
        logic [WIDTH-1:0] v;
        if (!in_range(a))
            v = '0;
        else if (ZR && a == '0)
            v = '0;
        else if (wr_en && wa == a)
            v = wd;
        else
            v = memv;
        return v;
    endfunction

    assign w_wr_en = we && in_range(waddr) && !(ZR && waddr == '0);
    assign w_err   = (we  && !in_range(waddr))  ||
                     (re1 && !in_range(raddr1)) ||
                     (re2 && !in_range(raddr2));

    // Decoded lookup keeps out-of-range addresses from indexing past the array.
    always_comb begin
        w_mem_rd1 = '0;
        w_mem_rd2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr1 == AW'(i)) w_mem_rd1 = r_mem[i];
            if (raddr2 == AW'(i)) w_mem_rd2 = r_mem[i];
        end
    end

    assign w_rd1 = port_value(raddr1, w_mem_rd1, we, waddr, wdata);
    assign w_rd2 = port_value(raddr2, w_mem_rd2, we, waddr, wdata);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (w_wr_en && waddr == AW'(i)) r_mem[i] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata1  <= '0;
            r_rdata2  <= '0;
            r_rvalid1 <= 1'b0;
            r_rvalid2 <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (re1) r_rdata1 <= w_rd1;
            if (re2) r_rdata2 <= w_rd2;
            r_rvalid1 <= re1;
            r_rvalid2 <= re2;
            r_err     <= w_err;
        end
    end

    assign rdata1  = r_rdata1;
    assign rdata2  = r_rdata2;
    assign rvalid1 = r_rvalid1;
    assign rvalid2 = r_rvalid2;
    assign err     = r_err;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Three regfile configurations driven from one random stream and checked every
// cycle against an array-based model, plus literal directed expectations.
module tb_regfile_2r1w;

    localparam int CW [3] = '{17, 17, 6};
    localparam int CD [3] = '{8, 6, 16};
    localparam int CA [3] = '{3, 3, 4};
    localparam int CZ [3] = '{0, 1, 0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, re1, re2;
    logic [3:0]  waddr, raddr1, raddr2;
    logic [16:0] wdata;
    logic        chk_en = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [16:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic [5:0]  c_rd1, c_rd2;
    logic        a_v1, a_v2, a_err, b_v1, b_v2, b_err, c_v1, c_v2, c_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_2r1w #(.WIDTH(17), .DEPTH(8), .AW(3), .ZERO_REG(0)) u_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr[2:0]), .wdata(wdata),
        .re1(re1), .raddr1(raddr1[2:0]), .rdata1(a_rd1), .rvalid1(a_v1),
        .re2(re2), .raddr2(raddr2[2:0]), .rdata2(a_rd2), .rvalid2(a_v2),
        .err(a_err));

    regfile_2r1w #(.WIDTH(17), .DEPTH(6), .AW(3), .ZERO_REG(1)) u_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr[2:0]), .wdata(wdata),
        .re1(re1), .raddr1(raddr1[2:0]), .rdata1(b_rd1), .rvalid1(b_v1),
        .re2(re2), .raddr2(raddr2[2:0]), .rdata2(b_rd2), .rvalid2(b_v2),
        .err(b_err));

    regfile_2r1w #(.WIDTH(6), .DEPTH(16), .AW(4), .ZERO_REG(0)) u_c (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata[5:0]),
        .re1(re1), .raddr1(raddr1), .rdata1(c_rd1), .rvalid1(c_v1),
        .re2(re2), .raddr2(raddr2), .rdata2(c_rd2), .rvalid2(c_v2),
        .err(c_err));

    // Reference model: plain arrays, one per configuration.
    logic [16:0] m_mem [3][16];
    logic [16:0] e_rd1 [3];
    logic [16:0] e_rd2 [3];
    logic        e_v1 [3];
    logic        e_v2 [3];
    logic        e_err [3];

    function automatic logic [16:0] mval(int k, int a, int wa, logic [16:0] wd);
        if (a >= CD[k]) return 17'd0;
        if (CZ[k] != 0 && a == 0) return 17'd0;
        if (we && wa == a) return wd;
        return m_mem[k][a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 16; j++) m_mem[k][j] <= 17'd0;
                e_rd1[k] <= 17'd0;
                e_rd2[k] <= 17'd0;
                e_v1[k]  <= 1'b0;
                e_v2[k]  <= 1'b0;
                e_err[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                int am, wa, a1, a2;
                logic [16:0] wd;
                am = (1 << CA[k]) - 1;
                wa = int'(waddr) & am;
                a1 = int'(raddr1) & am;
                a2 = int'(raddr2) & am;
                wd = wdata & 17'((1 << CW[k]) - 1);
                if (re1) e_rd1[k] <= mval(k, a1, wa, wd);
                if (re2) e_rd2[k] <= mval(k, a2, wa, wd);
                e_v1[k]  <= re1;
                e_v2[k]  <= re2;
                e_err[k] <= (we && wa >= CD[k]) || (re1 && a1 >= CD[k]) || (re2 && a2 >= CD[k]);
                if (we && wa < CD[k] && !(CZ[k] != 0 && wa == 0)) m_mem[k][wa] <= wd;
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("A.rdata1", 32'(a_rd1), 32'(e_rd1[0]));
            chk("A.rdata2", 32'(a_rd2), 32'(e_rd2[0]));
            chk("A.rvalid1", 32'(a_v1), 32'(e_v1[0]));
            chk("A.rvalid2", 32'(a_v2), 32'(e_v2[0]));
            chk("A.err", 32'(a_err), 32'(e_err[0]));
            chk("B.rdata1", 32'(b_rd1), 32'(e_rd1[1]));
            chk("B.rdata2", 32'(b_rd2), 32'(e_rd2[1]));
            chk("B.rvalid1", 32'(b_v1), 32'(e_v1[1]));
            chk("B.rvalid2", 32'(b_v2), 32'(e_v2[1]));
            chk("B.err", 32'(b_err), 32'(e_err[1]));
            chk("C.rdata1", 32'(c_rd1), 32'(e_rd1[2]));
            chk("C.rdata2", 32'(c_rd2), 32'(e_rd2[2]));
            chk("C.rvalid1", 32'(c_v1), 32'(e_v1[2]));
            chk("C.rvalid2", 32'(c_v2), 32'(e_v2[2]));
            chk("C.err", 32'(c_err), 32'(e_err[2]));
        end
    end

    task automatic idle();
        we = 1'b0; re1 = 1'b0; re2 = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [16:0] d);
        we = 1'b1; waddr = 4'(a); wdata = d;
    endtask

    initial begin
        idle();
        waddr = '0; raddr1 = '0; raddr2 = '0; wdata = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst A.rdata1", 32'(a_rd1), 32'h0);
        chk("rst B.err", 32'(b_err), 32'h0);
        rst_n = 1'b1;

        // Fill, then an asynchronous mid-cycle reset must wipe everything.
        for (int i = 0; i < 8; i++) begin
            wr(i, 17'h1ABCD);
            step();
        end
        idle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrst A.rvalid1", 32'(a_v1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            re1 = 1'b1; raddr1 = 4'(i);
            re2 = 1'b1; raddr2 = 4'(7 - i);
            step();
            chk("clr A.rdata1", 32'(a_rd1), 32'h0);
            chk("clr A.rdata2", 32'(a_rd2), 32'h0);
        end
        idle();

        // Basic write then dual read, then hold.
        wr(3, 17'h00055); step();
        wr(5, 17'h1FFFF); step();
        idle();
        re1 = 1'b1; raddr1 = 4'd3; re2 = 1'b1; raddr2 = 4'd5;
        step();
        chk("basic A.rdata1", 32'(a_rd1), 32'h00055);
        chk("basic A.rdata2", 32'(a_rd2), 32'h1FFFF);
        chk("basic A.rvalid1", 32'(a_v1), 32'h1);
        chk("basic A.rvalid2", 32'(a_v2), 32'h1);
        idle();
        step();
        chk("hold A.rdata1", 32'(a_rd1), 32'h00055);
        chk("hold A.rvalid1", 32'(a_v1), 32'h0);

        // Forwarding to both ports.
        wr(2, 17'h00011); step();
        wr(2, 17'h00022); re1 = 1'b1; raddr1 = 4'd2; re2 = 1'b1; raddr2 = 4'd2;
        step();
        chk("fwd A.rdata1", 32'(a_rd1), 32'h00022);
        chk("fwd A.rdata2", 32'(a_rd2), 32'h00022);
        idle();
        re1 = 1'b1; raddr1 = 4'd2;
        step();
        chk("fwd2 A.rdata1", 32'(a_rd1), 32'h00022);

        // Zero register (config B) versus a plain word 0 (config A).
        idle();
        wr(0, 17'h01234); re1 = 1'b1; raddr1 = 4'd0;
        step();
        chk("zero B.rdata1", 32'(b_rd1), 32'h0);
        chk("zero B.err", 32'(b_err), 32'h0);
        chk("zero A.rdata1", 32'(a_rd1), 32'h01234);
        idle();
        re1 = 1'b1; raddr1 = 4'd0; re2 = 1'b1; raddr2 = 4'd0;
        step();
        chk("zero2 B.rdata1", 32'(b_rd1), 32'h0);
        chk("zero2 A.rdata2", 32'(a_rd2), 32'h01234);

        // Out-of-range access on the DEPTH=6 configuration.
        idle();
        wr(7, 17'h00F0F); re1 = 1'b1; raddr1 = 4'd6;
        step();
        chk("oor B.rdata1", 32'(b_rd1), 32'h0);
        chk("oor B.err", 32'(b_err), 32'h1);
        chk("oor A.err", 32'(a_err), 32'h0);
        idle();
        re1 = 1'b1; raddr1 = 4'd3; re2 = 1'b1; raddr2 = 4'd5;
        step();
        chk("oor2 B.err", 32'(b_err), 32'h0);
        chk("oor2 B.rdata1", 32'(b_rd1), 32'h00055);
        chk("oor2 B.rdata2", 32'(b_rd2), 32'h1FFFF);

        // Random traffic, model compared every cycle.
        for (int n = 0; n < 10000; n++) begin
            we     = 1'($urandom);
            re1    = 1'($urandom);
            re2    = 1'($urandom);
            waddr  = 4'($urandom);
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
            raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 4'($urandom);
            wdata  = 17'($urandom);
            step();
        end
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file: DEPTH words of WIDTH bits, one synchronous write port and two independent registered read ports with write-to-read forwarding. Generalises the single-word 17-bit dual-read storage cell of the 6-bit CPU datapath into an addressable bank. It serves as the CPU general register bank and as wider scratch storage. All storage is cleared by reset, and an optional hard-wired zero register is available.

## Interface
Parameters:
- WIDTH, 17, data width of each word (≥1)
- DEPTH, 8, number of words (≥2; need not be a power of two)
- AW, 3, address width; must satisfy 2^AW ≥ DEPTH
- ZERO_REG, 0, when 1 word 0 always reads 0 and writes to it are dropped

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- re1  in  1  read-port-1 enable
- raddr1  in  AW  read-port-1 address
- rdata1  out  WIDTH  read-port-1 data, registered
- rvalid1  out  1  rdata1 was updated at the last edge by an accepted read
- re2, raddr2, rdata2, rvalid2  same as port 1, for port 2
- err  out  1  registered pulse: some access this cycle hit address ≥ DEPTH

## Operation
- Storage: DEPTH × WIDTH flops; no latches, no combinational read path to outputs.
- Write: on an edge with we=1 and waddr<DEPTH, mem[waddr] ← wdata. If ZERO_REG=1 and waddr=0, the write is dropped (not an error).
- Read port k: on an edge with rek=1, rdatak ← value(raddrk) and rvalidk ← 1. With rek=0, rdatak holds its previous value and rvalidk ← 0.
- value(a):
  - a ≥ DEPTH gives 0.
  - else ZERO_REG=1 and a=0 gives 0.
  - else we=1 and waddr=a gives wdata (forwarding: a read in the same cycle as a write to the same address returns the new data).
  - else mem[a].
- Both ports may read the same address in the same cycle; both receive the identical value.
- Out-of-range: a write with waddr≥DEPTH changes no word. err ← 1 on the next edge if any of these holds in the current cycle:
  - we=1 and waddr≥DEPTH
  - re1=1 and raddr1≥DEPTH
  - re2=1 and raddr2≥DEPTH
  - otherwise err ← 0.
- No state machine beyond storage and output registers. Port behaviour is fully independent except for the shared forwarding source.

## Timing
- Reset (rst_n=0, asynchronous): every mem word, rdata1, rdata2 = 0; rvalid1, rvalid2, err = 0. Held while rst_n=0.
- Reset release: the first edge with rst_n=1 behaves as a normal cycle. Inputs are sampled at that edge.
- Reset asserted mid-write: the write is lost and the word reads 0 afterwards.
- Write latency: a word written at edge N is visible through mem to reads sampled at edge N+1. It is visible through forwarding to reads sampled at edge N.
- Read latency: 1 cycle; rdatak/rvalidk are valid immediately after the sampling edge.
- Throughput: one write and two reads per cycle, no stalls, no back-pressure.
- err: valid one cycle after the offending access, for exactly one cycle per offending cycle.

## Test plan
- Reset clear: write 0x1ABCD to all 8 words, pulse rst_n low asynchronously mid-cycle, then read all words → rdata=0 on both ports, and all outputs were 0 during reset.
- Basic write/read: write word3=0x00055 and word5=0x1FFFF, then read re1@3 and re2@5 in the same cycle → next cycle rdata1=0x00055, rdata2=0x1FFFF, rvalid1=rvalid2=1. Following cycle with re=0 → data held, rvalid=0.
- Forwarding: word2=0x00011, then in one cycle we=1 waddr=2 wdata=0x00022 with re1@2 and re2@2 → both rdata=0x00022; a subsequent read → 0x00022.
- ZERO_REG=1: write 0x1234 to word 0 → read word 0 returns 0 (including the forwarding cycle), err=0.
- Out-of-range (DEPTH=6, AW=3): write 0x0F0F to addr 7, read raddr1=6 → rdata1=0, err=1 for one cycle, and all words 0–5 unchanged.
- Random: 10k cycles of random we/re/addresses against a scoreboard model, for WIDTH=17/DEPTH=8 and WIDTH=6/DEPTH=16 → zero mismatches.
